// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_REQ read masters.
// One burst is outstanding at a time; R beats are steered to the owner until RLAST.

module axi_rd_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  // Requester side
  input  logic [NUM_REQ*ADDR_W-1:0] S_AXI_araddr,
  input  logic [NUM_REQ*8-1:0]      S_AXI_arlen,
  input  logic [NUM_REQ*3-1:0]      S_AXI_arsize,
  input  logic [NUM_REQ*2-1:0]      S_AXI_arburst,
  input  logic [NUM_REQ-1:0]        S_AXI_arvalid,
  output logic [NUM_REQ-1:0]        S_AXI_arready,
  output logic [DATA_W-1:0]         S_AXI_rdata,
  output logic [1:0]                S_AXI_rresp,
  output logic                      S_AXI_rlast,
  output logic [NUM_REQ-1:0]        S_AXI_rvalid,
  input  logic [NUM_REQ-1:0]        S_AXI_rready,
  // DDR controller side
  output logic [ADDR_W-1:0]         M_AXI_araddr,
  output logic [7:0]                M_AXI_arlen,
  output logic [2:0]                M_AXI_arsize,
  output logic [1:0]                M_AXI_arburst,
  output logic [3:0]                M_AXI_arid,
  output logic [3:0]                M_AXI_arcache,
  output logic [3:0]                M_AXI_arqos,
  output logic [1:0]                M_AXI_arlock,
  output logic [2:0]                M_AXI_arprot,
  output logic                      M_AXI_arvalid,
  input  logic                      M_AXI_arready,
  input  logic [DATA_W-1:0]         M_AXI_rdata,
  input  logic [1:0]                M_AXI_rresp,
  input  logic [3:0]                M_AXI_rid,
  input  logic                      M_AXI_rlast,
  input  logic                      M_AXI_rvalid,
  output logic                      M_AXI_rready,
  // Status
  output logic                      busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic [7:0]        beat_cnt_q;
  logic              err_q;
  logic              err_d;

  logic              rr_hit;
  logic [IDX_W-1:0]  rr_sel;
  logic [IDX_W-1:0]  cand_idx;
  logic              r_fire;
  logic              beat_bad;

  // Search begins just past the previous owner, so a finishing owner ranks last.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    rr_hit   = 1'b0;
    rr_sel   = '0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!rr_hit && S_AXI_arvalid[cand_idx]) begin
        rr_hit = 1'b1;
        rr_sel = cand_idx;
      end
    end
  end

  assign r_fire   = (state_q == ST_DATA) & M_AXI_rvalid & S_AXI_rready[owner_q];
  assign beat_bad = (M_AXI_rid != 4'(owner_q)) | (M_AXI_rlast != (beat_cnt_q == arlen_q));
  assign err_d    = err_q | (r_fire & beat_bad);

  // NOTE: reset is synchronous, so it lives inside the clocked block with no edge on ARESET.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        ST_IDLE: begin
          if (rr_hit) begin
            araddr_q   <= S_AXI_araddr[int'(rr_sel)*ADDR_W +: ADDR_W];
            arlen_q    <= S_AXI_arlen[int'(rr_sel)*8 +: 8];
            arsize_q   <= S_AXI_arsize[int'(rr_sel)*3 +: 3];
            arburst_q  <= S_AXI_arburst[int'(rr_sel)*2 +: 2];
            owner_q    <= rr_sel;
            beat_cnt_q <= '0;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (M_AXI_arready) state_q <= ST_DATA;
        end
        ST_DATA: begin
          if (r_fire) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            // A missing RLAST keeps us here; only the real RLAST releases the port.
            if (M_AXI_rlast) begin
              last_grant_q <= owner_q;
              state_q      <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    S_AXI_arready = '0;
    S_AXI_rvalid  = '0;
    grant         = '0;
    if (state_q == ST_IDLE && rr_hit) S_AXI_arready[rr_sel] = 1'b1;
    if (state_q == ST_DATA) S_AXI_rvalid[owner_q] = M_AXI_rvalid;
    if (state_q != ST_IDLE) grant[owner_q] = 1'b1;
  end

  assign M_AXI_rready  = (state_q == ST_DATA) & S_AXI_rready[owner_q];
  assign S_AXI_rdata   = M_AXI_rdata;
  assign S_AXI_rresp   = M_AXI_rresp;
  assign S_AXI_rlast   = M_AXI_rlast;

  assign M_AXI_arvalid = (state_q == ST_ADDR);
  assign M_AXI_araddr  = araddr_q;
  assign M_AXI_arlen   = arlen_q;
  assign M_AXI_arsize  = arsize_q;
  assign M_AXI_arburst = arburst_q;
  assign M_AXI_arid    = 4'(owner_q);
  assign M_AXI_arcache = 4'b0011;
  assign M_AXI_arqos   = 4'b0000;
  assign M_AXI_arlock  = 2'b00;
  assign M_AXI_arprot  = 3'b000;

  assign busy = (state_q != ST_IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter with four requesters: arbitration table,
// hand-written corner sequences and a randomized run against a transaction-level model.

module tb_axi_rd_arbiter;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 256;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NR*AW-1:0]  S_AXI_araddr;
  logic [NR*8-1:0]   S_AXI_arlen;
  logic [NR*3-1:0]   S_AXI_arsize;
  logic [NR*2-1:0]   S_AXI_arburst;
  logic [NR-1:0]     S_AXI_arvalid;
  logic [NR-1:0]     S_AXI_arready;
  logic [DW-1:0]     S_AXI_rdata;
  logic [1:0]        S_AXI_rresp;
  logic              S_AXI_rlast;
  logic [NR-1:0]     S_AXI_rvalid;
  logic [NR-1:0]     S_AXI_rready;
  logic [AW-1:0]     M_AXI_araddr;
  logic [7:0]        M_AXI_arlen;
  logic [2:0]        M_AXI_arsize;
  logic [1:0]        M_AXI_arburst;
  logic [3:0]        M_AXI_arid;
  logic [3:0]        M_AXI_arcache;
  logic [3:0]        M_AXI_arqos;
  logic [1:0]        M_AXI_arlock;
  logic [2:0]        M_AXI_arprot;
  logic              M_AXI_arvalid;
  logic              M_AXI_arready;
  logic [DW-1:0]     M_AXI_rdata;
  logic [1:0]        M_AXI_rresp;
  logic [3:0]        M_AXI_rid;
  logic              M_AXI_rlast;
  logic              M_AXI_rvalid;
  logic              M_AXI_rready;
  logic              busy;
  logic [NR-1:0]     grant;
  logic              err;

  axi_rd_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_araddr(S_AXI_araddr), .S_AXI_arlen(S_AXI_arlen), .S_AXI_arsize(S_AXI_arsize),
    .S_AXI_arburst(S_AXI_arburst), .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
    .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp), .S_AXI_rlast(S_AXI_rlast),
    .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
    .M_AXI_araddr(M_AXI_araddr), .M_AXI_arlen(M_AXI_arlen), .M_AXI_arsize(M_AXI_arsize),
    .M_AXI_arburst(M_AXI_arburst), .M_AXI_arid(M_AXI_arid), .M_AXI_arcache(M_AXI_arcache),
    .M_AXI_arqos(M_AXI_arqos), .M_AXI_arlock(M_AXI_arlock), .M_AXI_arprot(M_AXI_arprot),
    .M_AXI_arvalid(M_AXI_arvalid), .M_AXI_arready(M_AXI_arready),
    .M_AXI_rdata(M_AXI_rdata), .M_AXI_rresp(M_AXI_rresp), .M_AXI_rid(M_AXI_rid),
    .M_AXI_rlast(M_AXI_rlast), .M_AXI_rvalid(M_AXI_rvalid), .M_AXI_rready(M_AXI_rready),
    .busy(busy), .grant(grant), .err(err)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] req_addr  [NR];
  logic [7:0]    req_len   [NR];
  logic [2:0]    req_size  [NR];
  logic [1:0]    req_burst [NR];

  typedef struct {
    logic [3:0] mask;
    int         len;
    int         exp_owner;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic pack_fields();
    for (int i = 0; i < NR; i++) begin
      S_AXI_araddr[i*AW +: AW] = req_addr[i];
      S_AXI_arlen[i*8 +: 8]    = req_len[i];
      S_AXI_arsize[i*3 +: 3]   = req_size[i];
      S_AXI_arburst[i*2 +: 2]  = req_burst[i];
    end
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    S_AXI_arvalid = '0;
    S_AXI_rready  = '0;
    M_AXI_arready = 1'b0;
    M_AXI_rvalid  = 1'b0;
    M_AXI_rlast   = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  // Requester-level round-robin rule: first set bit after the last owner, wrapping.
  function automatic int rr_pick(input int last, input logic [3:0] mask);
    for (int k = 1; k <= NR; k++)
      if (mask[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction

  task automatic accept(input logic [3:0] mask, input int exp_owner, input int ar_delay,
                        input bit hold, output int ar_edge);
    pack_fields();
    S_AXI_arvalid = mask;
    M_AXI_rvalid  = 1'b0;
    M_AXI_arready = 1'b0;
    #1;
    check("idle_busy", 256'(busy), 256'(0));
    check("arready_pick", 256'(S_AXI_arready), 256'(4'b0001 << exp_owner));
    check("arvalid_before_accept", 256'(M_AXI_arvalid), 256'(0));
    tick();
    if (!hold) S_AXI_arvalid = '0;
    for (int i = 0; i <= ar_delay; i++) begin
      M_AXI_arready = (i == ar_delay);
      M_AXI_rvalid  = 1'b1;   // stray beat while in ADDR must be ignored
      M_AXI_rlast   = 1'b0;
      S_AXI_rready  = '1;
      #1;
      check("ar_valid", 256'(M_AXI_arvalid), 256'(1));
      check("ar_addr", 256'(M_AXI_araddr), 256'(req_addr[exp_owner]));
      check("ar_len", 256'(M_AXI_arlen), 256'(req_len[exp_owner]));
      check("ar_size_burst", 256'({M_AXI_arsize, M_AXI_arburst}),
            256'({req_size[exp_owner], req_burst[exp_owner]}));
      check("ar_id", 256'(M_AXI_arid), 256'(exp_owner));
      check("addr_grant", 256'(grant), 256'(4'b0001 << exp_owner));
      check("addr_no_arready", 256'(S_AXI_arready), 256'(0));
      check("addr_rready_off", 256'({M_AXI_rready, S_AXI_rvalid}), 256'(0));
      tick();
    end
    M_AXI_arready = 1'b0;
    M_AXI_rvalid  = 1'b0;
    ar_edge = cyc;
  endtask

  // bp_mode: 0 always ready, 1 owner rready toggles 1/0, 2 random valid/ready.
  task automatic do_burst(input logic [3:0] mask, input int exp_owner, input int ar_delay,
                          input int bp_mode, input bit hold, input bit exp_err,
                          output int ar_edge, output int rlast_edge);
    logic [255:0] sent_q[$];
    logic [255:0] got_q[$];
    logic [255:0] d;
    int len, b, guard;
    bit rv, rr;
    len = int'(req_len[exp_owner]);
    accept(mask, exp_owner, ar_delay, hold, ar_edge);
    b = 0;
    guard = 0;
    while (b <= len && guard < 40 * (len + 1)) begin
      case (bp_mode)
        0:       begin rv = 1'b1; rr = 1'b1; end
        1:       begin rv = 1'b1; rr = (guard % 2 == 0); end
        default: begin rv = ($urandom_range(0, 3) != 0); rr = ($urandom_range(0, 2) != 0); end
      endcase
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      M_AXI_rvalid = rv;
      M_AXI_rdata  = d;
      M_AXI_rlast  = (b == len);
      M_AXI_rid    = 4'(exp_owner);
      M_AXI_rresp  = 2'(b);
      S_AXI_rready = 4'($urandom);
      S_AXI_rready[exp_owner] = rr;
      #1;
      check("r_valid_route", 256'(S_AXI_rvalid), 256'(4'(rv) << exp_owner));
      check("r_ready_mirror", 256'(M_AXI_rready), 256'(rr));
      check("r_side_bcast", 256'({S_AXI_rresp, S_AXI_rlast}), 256'({2'(b), b == len}));
      if (S_AXI_rvalid[exp_owner] && S_AXI_rready[exp_owner]) got_q.push_back(S_AXI_rdata);
      if (rv && M_AXI_rready) begin
        sent_q.push_back(d);
        b++;
      end
      tick();
      guard++;
    end
    rlast_edge = cyc;
    if (b <= len) begin
      n_checks++;
      n_fail++;
      $display("FAIL burst_timeout: %0d beats of %0d accepted", b, len + 1);
    end
    M_AXI_rvalid = 1'b0;
    M_AXI_rlast  = 1'b0;
    if (!hold) S_AXI_arvalid = '0;
    #1;
    check("end_busy", 256'(busy), 256'(0));
    check("end_grant", 256'(grant), 256'(0));
    check("end_err", 256'(err), 256'(exp_err));
    check("beats_delivered", 256'(got_q.size()), 256'(len + 1));
    for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
      check("beat_data", got_q[i], sent_q[i]);
  endtask

  task automatic beat(input logic [3:0] rid, input bit last);
    M_AXI_rvalid = 1'b1;
    M_AXI_rid    = rid;
    M_AXI_rlast  = last;
    M_AXI_rdata  = 256'(cyc);
    S_AXI_rready = '1;
    #1;
    tick();
    M_AXI_rvalid = 1'b0;
    M_AXI_rlast  = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ar_e, rl_e, prev_rl, lg, ex;
    logic [3:0] mask;

    vecs[0]  = '{4'b0011, 0, 0};
    vecs[1]  = '{4'b0011, 0, 1};
    vecs[2]  = '{4'b0011, 0, 0};
    vecs[3]  = '{4'b0011, 0, 1};
    vecs[4]  = '{4'b1010, 1, 3};
    vecs[5]  = '{4'b1010, 1, 1};
    vecs[6]  = '{4'b1111, 2, 2};
    vecs[7]  = '{4'b1111, 0, 3};
    vecs[8]  = '{4'b1111, 0, 0};
    vecs[9]  = '{4'b0001, 1, 0};
    vecs[10] = '{4'b0100, 0, 2};
    vecs[11] = '{4'b1001, 0, 3};

    for (int i = 0; i < NR; i++) begin
      req_addr[i] = 32'h1000 * (i + 1) + 32'h40;
      req_len[i] = 8'd0;
      req_size[i] = 3'd5;
      req_burst[i] = 2'b01;
    end
    S_AXI_rready = '0;
    M_AXI_rdata = '0;
    M_AXI_rresp = '0;
    M_AXI_rid = '0;
    pack_fields();
    do_reset();

    // Reset state
    #1;
    check("rst_status", 256'({busy, grant, err}), 256'(0));
    check("rst_handshakes", 256'({M_AXI_arvalid, M_AXI_rready, S_AXI_arready, S_AXI_rvalid}), 256'(0));
    check("rst_fields", 256'({M_AXI_araddr, M_AXI_arlen, M_AXI_arsize, M_AXI_arburst}), 256'(0));
    check("const_fields", 256'({M_AXI_arcache, M_AXI_arqos, M_AXI_arlock, M_AXI_arprot}),
          256'({4'b0011, 4'b0000, 2'b00, 3'b000}));

    // Stray R beat in IDLE is ignored
    M_AXI_rvalid = 1'b1; M_AXI_rlast = 1'b1; M_AXI_rid = 4'd0; S_AXI_rready = '1;
    #1;
    check("idle_rready_off", 256'({M_AXI_rready, S_AXI_rvalid}), 256'(0));
    tick();
    M_AXI_rvalid = 1'b0; M_AXI_rlast = 1'b0;
    #1;
    check("idle_stray_no_err", 256'({err, busy}), 256'(0));

    // Arbitration table, requests held continuously (back-to-back bursts)
    prev_rl = -1;
    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < NR; i++) req_len[i] = 8'(vecs[v].len);
      do_burst(vecs[v].mask, vecs[v].exp_owner, 0, 0, 1'b1, 1'b0, ar_e, rl_e);
      if (prev_rl >= 0) check("turnaround", 256'(ar_e - prev_rl), 256'(2));
      prev_rl = rl_e;
    end
    S_AXI_arvalid = '0;

    // Single request: requester 0, araddr 0x100, arlen 4
    do_reset();
    req_addr[0] = 32'h100; req_len[0] = 8'd4;
    do_burst(4'b0001, 0, 0, 0, 1'b0, 1'b0, ar_e, rl_e);

    // Backpressure: arlen 7, owner rready toggles
    req_len[0] = 8'd7;
    do_burst(4'b0001, 0, 1, 1, 1'b0, 1'b0, ar_e, rl_e);

    // Early rlast on beat 3 of an arlen=4 burst
    do_reset();
    req_len[0] = 8'd4;
    accept(4'b0001, 0, 0, 1'b0, ar_e);
    beat(4'd0, 1'b0);
    beat(4'd0, 1'b0);
    #1;
    check("err_quiet", 256'(err), 256'(0));
    beat(4'd0, 1'b1);
    #1;
    check("err_early_rlast", 256'({err, busy}), 256'(2'b10));
    tick();
    check("err_sticky", 256'(err), 256'(1));
    req_len[0] = 8'd0;
    do_burst(4'b0001, 0, 0, 0, 1'b0, 1'b1, ar_e, rl_e);

    // Wrong rid
    do_reset();
    #1;
    check("err_cleared", 256'(err), 256'(0));
    accept(4'b0001, 0, 0, 1'b0, ar_e);
    beat(4'd2, 1'b1);
    #1;
    check("err_bad_rid", 256'(err), 256'(1));

    // Missing rlast on the final beat keeps the burst open
    do_reset();
    req_len[0] = 8'd1;
    accept(4'b0001, 0, 0, 1'b0, ar_e);
    beat(4'd0, 1'b0);
    #1;
    check("err_ok_first", 256'(err), 256'(0));
    beat(4'd0, 1'b0);
    #1;
    check("err_no_rlast", 256'({err, busy}), 256'(2'b11));
    beat(4'd0, 1'b1);
    #1;
    check("late_rlast_idle", 256'(busy), 256'(0));

    // Reset after beat 2 of 5
    do_reset();
    req_len[0] = 8'd4;
    accept(4'b0001, 0, 0, 1'b0, ar_e);
    beat(4'd0, 1'b0);
    beat(4'd0, 1'b0);
    ARESET = 1'b1; M_AXI_rvalid = 1'b1; S_AXI_rready = '1;
    tick();
    ARESET = 1'b0;
    #1;
    check("rst_mid_status", 256'({busy, grant}), 256'(0));
    check("rst_mid_hs", 256'({M_AXI_rready, S_AXI_rvalid, M_AXI_arvalid}), 256'(0));
    M_AXI_rvalid = 1'b0;
    for (int i = 0; i < NR; i++) req_len[i] = 8'd4;
    do_burst(4'b0011, 0, 0, 0, 1'b0, 1'b0, ar_e, rl_e);

    // Randomized run against the round-robin model
    do_reset();
    lg = NR - 1;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        S_AXI_arvalid = '0;
        #1;
        check("rand_idle", 256'({S_AXI_arready, busy}), 256'(0));
        tick();
      end else begin
        for (int i = 0; i < NR; i++) begin
          req_addr[i] = $urandom;
          req_len[i] = 8'($urandom_range(0, 7));
          req_size[i] = 3'($urandom);
          req_burst[i] = 2'($urandom);
        end
        mask = 4'($urandom_range(1, 15));
        ex = rr_pick(lg, mask);
        do_burst(mask, ex, $urandom_range(0, 2), 2, 1'b0, 1'b0, ar_e, rl_e);
        lg = ex;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
